pc_sequencer: RTL and testbench

- Control block in the IF stage of the 5-stage pipeline.
- Computes next_pc and stall for the program-counter register.
- Arbitrates among sequential fetch, jump redirects (from ID), taken-branch redirects (from EX), trap entry and halt.
- Also:
  - generates pipeline flushes;
  - holds the PC while instruction memory is not ready;
  - remembers a redirect that arrives while memory is busy.

---
 rtl/pc_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: IF-stage next-PC selection, stall and flush generation, with a
//   pending-redirect register that holds a redirect seen while imem is busy.
// Latency: next_pc/stall/flush_* are combinational from state and inputs; the
//   state, pending redirect and trap counter update on the rising clk edge.
// Backpressure: imem_ready=0 stalls the PC (WAIT_MEM); load_use_hazard freezes
//   one cycle; trap entry stalls TRAP_FLUSH_CYCLES cycles; HALTED stalls forever.
//
// Ports: clk, rst (async, active high); current_pc; imem_ready; jump_id/jump_target;
//   branch_taken_ex/branch_target; load_use_hazard; trap_req; halt_req;
//   next_pc, stall, flush_ifid, flush_idex, seq_state (0 RUN, 1 WAIT_MEM,
//   2 TRAP_FLUSH, 3 HALTED).
// Optional: define PC_SEQ_PERF_EN to add saturating stall_cycles and
//   redirect_count outputs.
module pc_sequencer #(
  parameter int unsigned INSTR_BYTES       = 4,
  parameter logic [31:0] TRAP_VECTOR       = 32'h0000_0100,
  parameter int unsigned TRAP_FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] current_pc,
  input  logic        imem_ready,
  input  logic        jump_id,
  input  logic [31:0] jump_target,
  input  logic        branch_taken_ex,
  input  logic [31:0] branch_target,
  input  logic        load_use_hazard,
  input  logic        trap_req,
  input  logic        halt_req,
  output logic [31:0] next_pc,
  output logic        stall,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [1:0]  seq_state
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirect_count
`endif
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    WAIT_MEM   = 2'd1,
    TRAP_FLUSH = 2'd2,
    HALTED     = 2'd3
  } state_t;

  localparam logic [2:0] TRAP_CNT_INIT = 3'(TRAP_FLUSH_CYCLES);

  state_t      state, state_nxt;
  logic        pend_valid, pend_valid_nxt;
  logic [31:0] pend_target, pend_target_nxt;
  logic [2:0]  trap_cnt, trap_cnt_nxt;

  logic [31:0] seq_pc;
  logic        redir_req;
  logic [31:0] redir_target;

  assign seq_pc       = current_pc + 32'(INSTR_BYTES);
  assign redir_req    = branch_taken_ex | jump_id;
  // Branch from EX is older than the jump in ID, so it wins.
  assign redir_target = branch_taken_ex ? branch_target : jump_target;
  assign seq_state    = state;

  always_comb begin
    state_nxt       = state;
    pend_valid_nxt  = pend_valid;
    pend_target_nxt = pend_target;
    trap_cnt_nxt    = trap_cnt;
    next_pc         = seq_pc;
    stall           = 1'b0;
    flush_ifid      = 1'b0;
    flush_idex      = 1'b0;

    case (state)
      RUN, WAIT_MEM: begin
        if (trap_req) begin
          next_pc        = TRAP_VECTOR;
          stall          = 1'b1;
          flush_ifid     = 1'b1;
          flush_idex     = 1'b1;
          pend_valid_nxt = 1'b0;
          trap_cnt_nxt   = TRAP_CNT_INIT;
          state_nxt      = TRAP_FLUSH;
        end else if (state == RUN && halt_req) begin
          stall      = 1'b1;
          flush_ifid = 1'b1;
          state_nxt  = HALTED;
        end else if (redir_req) begin
          next_pc    = redir_target;
          flush_ifid = 1'b1;
          flush_idex = branch_taken_ex;
          if (imem_ready) begin
            pend_valid_nxt = 1'b0;
            state_nxt      = RUN;
          end else begin
            // Memory busy: remember the winner so it is not lost.
            stall           = 1'b1;
            pend_valid_nxt  = 1'b1;
            pend_target_nxt = redir_target;
            state_nxt       = WAIT_MEM;
          end
        end else if (state == RUN) begin
          if (load_use_hazard) begin
            stall = 1'b1;
          end else if (!imem_ready) begin
            stall     = 1'b1;
            state_nxt = WAIT_MEM;
          end
        end else if (imem_ready) begin
          next_pc        = pend_valid ? pend_target : seq_pc;
          pend_valid_nxt = 1'b0;
          state_nxt      = RUN;
        end else begin
          stall = 1'b1;
        end
      end

      TRAP_FLUSH: begin
        next_pc    = TRAP_VECTOR;
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
        if (trap_cnt <= 3'd1 && imem_ready) begin
          trap_cnt_nxt = 3'd0;
          state_nxt    = RUN;
        end else begin
          stall = 1'b1;
          // Count down to 1, then park there until memory is ready.
          if (trap_cnt > 3'd1) trap_cnt_nxt = trap_cnt - 3'd1;
        end
      end

      HALTED: begin
        stall      = 1'b1;
        flush_ifid = 1'b1;
      end

      default: state_nxt = RUN;
    endcase

    // While in reset the PC register loads 0 and the pipeline is squashed.
    if (rst) begin
      next_pc    = 32'h0;
      stall      = 1'b0;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0;
      trap_cnt    <= 3'd0;
    end else begin
      state       <= state_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_target <= pend_target_nxt;
      trap_cnt    <= trap_cnt_nxt;
    end
  end

`ifdef PC_SEQ_PERF_EN
  // An unstalled cycle carries a redirect target when leaving TRAP_FLUSH, when
  // a branch/jump is taken (it outranks the hazard freeze), or when a pending
  // redirect is replayed from WAIT_MEM.
  logic redirect_taken;
  assign redirect_taken = !rst && !stall &&
                          (state == TRAP_FLUSH || redir_req ||
                           (state == WAIT_MEM && pend_valid));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles   <= 32'h0;
      redirect_count <= 32'h0;
    end else begin
      if (stall && state != HALTED && stall_cycles != 32'hFFFF_FFFF)
        stall_cycles <= stall_cycles + 32'd1;
      if (redirect_taken && redirect_count != 32'hFFFF_FFFF)
        redirect_count <= redirect_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of pc_sequencer with hand-computed values.
// Inputs change 1 time unit after the rising edge, outputs are compared 1 unit
// later; flags are compared as {stall, flush_ifid, flush_idex, seq_state}.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] current_pc;
  logic        imem_ready;
  logic        jump_id;
  logic [31:0] jump_target;
  logic        branch_taken_ex;
  logic [31:0] branch_target;
  logic        load_use_hazard;
  logic        trap_req;
  logic        halt_req;
  logic [31:0] next_pc;
  logic        stall;
  logic        flush_ifid;
  logic        flush_idex;
  logic [1:0]  seq_state;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .current_pc      (current_pc),
    .imem_ready      (imem_ready),
    .jump_id         (jump_id),
    .jump_target     (jump_target),
    .branch_taken_ex (branch_taken_ex),
    .branch_target   (branch_target),
    .load_use_hazard (load_use_hazard),
    .trap_req        (trap_req),
    .halt_req        (halt_req),
    .next_pc         (next_pc),
    .stall           (stall),
    .flush_ifid      (flush_ifid),
    .flush_idex      (flush_idex),
    .seq_state       (seq_state)
  );

  always #5 clk = ~clk;

  wire [4:0] flags = {stall, flush_ifid, flush_idex, seq_state};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    imem_ready      = 1'b1;
    jump_id         = 1'b0;
    jump_target     = 32'h0;
    branch_taken_ex = 1'b0;
    branch_target   = 32'h0;
    load_use_hazard = 1'b0;
    trap_req        = 1'b0;
    halt_req        = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    current_pc = 32'h1234;
    #2;
    n_checks++;
    if (next_pc !== 32'h0) begin n_fail++; $display("FAIL reset_next_pc got=%h exp=%h", next_pc, 32'h0); end
    n_checks++;
    if (flags !== 5'b0_1_1_00) begin n_fail++; $display("FAIL reset_flags got=%b exp=%b", flags, 5'b0_1_1_00); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] pcs [4];
    logic [31:0] exp [4];
    pcs = '{32'h0, 32'h4, 32'h8, 32'hFFFF_FFFC};
    exp = '{32'h4, 32'h8, 32'hC, 32'h0};
    idle();
    for (int i = 0; i < 4; i++) begin
      current_pc = pcs[i];
      #1;
      n_checks++;
      if (next_pc !== exp[i]) begin n_fail++; $display("FAIL seq_%0d next_pc got=%h exp=%h", i, next_pc, exp[i]); end
      n_checks++;
      if (flags !== 5'b0_0_0_00) begin n_fail++; $display("FAIL seq_%0d flags got=%b exp=%b", i, flags, 5'b0_0_0_00); end
      tick();
    end
  endtask

  task automatic test_branch_jump();
    idle();
    current_pc = 32'h40;
    branch_taken_ex = 1'b1; branch_target = 32'h200;
    jump_id = 1'b1; jump_target = 32'h300;
    #1;
    n_checks++;
    if (next_pc !== 32'h200) begin n_fail++; $display("FAIL br_jmp next_pc got=%h exp=%h", next_pc, 32'h200); end
    n_checks++;
    if (flags !== 5'b0_1_1_00) begin n_fail++; $display("FAIL br_jmp flags got=%b exp=%b", flags, 5'b0_1_1_00); end
    tick();
    idle();
    current_pc = 32'h60;
    jump_id = 1'b1; jump_target = 32'h340;
    #1;
    n_checks++;
    if (next_pc !== 32'h340) begin n_fail++; $display("FAIL jmp next_pc got=%h exp=%h", next_pc, 32'h340); end
    n_checks++;
    if (flags !== 5'b0_1_0_00) begin n_fail++; $display("FAIL jmp flags got=%b exp=%b", flags, 5'b0_1_0_00); end
    tick();
    idle();
  endtask

  task automatic test_wait_mem();
    logic [4:0] exp_f [5];
    exp_f = '{5'b1_1_0_00, 5'b1_0_0_01, 5'b1_0_0_01, 5'b0_0_0_01, 5'b0_0_0_00};
    idle();
    current_pc = 32'h80;
    for (int i = 0; i < 5; i++) begin
      jump_id     = (i == 0);
      jump_target = 32'h500;
      imem_ready  = (i >= 3);
      #1;
      n_checks++;
      if (flags !== exp_f[i]) begin n_fail++; $display("FAIL wait_%0d flags got=%b exp=%b", i, flags, exp_f[i]); end
      if (i == 3) begin
        n_checks++;
        if (next_pc !== 32'h500) begin n_fail++; $display("FAIL wait_replay next_pc got=%h exp=%h", next_pc, 32'h500); end
      end
      tick();
      if (i == 3) current_pc = 32'h500;
    end
    // A branch arriving during WAIT_MEM overwrites the pending jump.
    idle();
    current_pc = 32'h90;
    jump_id = 1'b1; jump_target = 32'h600; imem_ready = 1'b0;
    tick();
    jump_id = 1'b0; branch_taken_ex = 1'b1; branch_target = 32'h700;
    #1;
    n_checks++;
    if (flags !== 5'b1_1_1_01) begin n_fail++; $display("FAIL ovw_br flags got=%b exp=%b", flags, 5'b1_1_1_01); end
    tick();
    branch_taken_ex = 1'b0;
    tick();
    imem_ready = 1'b1;
    #1;
    n_checks++;
    if (next_pc !== 32'h700) begin n_fail++; $display("FAIL ovw_replay next_pc got=%h exp=%h", next_pc, 32'h700); end
    tick();
    // Plain memory wait without redirect resumes sequentially.
    current_pc = 32'hA0; imem_ready = 1'b0;
    #1;
    n_checks++;
    if (flags !== 5'b1_0_0_00) begin n_fail++; $display("FAIL memwait flags got=%b exp=%b", flags, 5'b1_0_0_00); end
    tick();
    imem_ready = 1'b1;
    #1;
    n_checks++;
    if (next_pc !== 32'hA4) begin n_fail++; $display("FAIL memwait next_pc got=%h exp=%h", next_pc, 32'hA4); end
    tick();
    idle();
  endtask

  task automatic test_load_use();
    idle();
    current_pc = 32'h10; load_use_hazard = 1'b1;
    #1;
    n_checks++;
    if (flags !== 5'b1_0_0_00) begin n_fail++; $display("FAIL hazard flags got=%b exp=%b", flags, 5'b1_0_0_00); end
    tick();
    load_use_hazard = 1'b0;
    #1;
    n_checks++;
    if (next_pc !== 32'h14 || flags !== 5'b0_0_0_00) begin
      n_fail++; $display("FAIL hazard_after next_pc=%h flags=%b exp 14/00000", next_pc, flags);
    end
    tick();
    load_use_hazard = 1'b1; jump_id = 1'b1; jump_target = 32'h900;
    #1;
    n_checks++;
    if (next_pc !== 32'h900 || flags !== 5'b0_1_0_00) begin
      n_fail++; $display("FAIL hazard_jmp next_pc=%h flags=%b exp 900/01000", next_pc, flags);
    end
    tick();
    idle();
  endtask

  task automatic test_trap();
    idle();
    current_pc = 32'h24; trap_req = 1'b1;
    #1;
    n_checks++;
    if (flags !== 5'b1_1_1_00) begin n_fail++; $display("FAIL trap_c0 flags got=%b exp=%b", flags, 5'b1_1_1_00); end
    tick();
    trap_req = 1'b0; branch_taken_ex = 1'b1; branch_target = 32'h800;
    #1;
    n_checks++;
    if (flags !== 5'b1_1_1_10) begin n_fail++; $display("FAIL trap_c1 flags got=%b exp=%b", flags, 5'b1_1_1_10); end
    tick();
    n_checks++;
    if (next_pc !== 32'h100 || flags !== 5'b0_1_1_10) begin
      n_fail++; $display("FAIL trap_exit next_pc=%h flags=%b exp 100/01110", next_pc, flags);
    end
    tick();
    idle(); current_pc = 32'h100;
    #1;
    n_checks++;
    if (next_pc !== 32'h104 || flags !== 5'b0_0_0_00) begin
      n_fail++; $display("FAIL trap_after next_pc=%h flags=%b exp 104/00000", next_pc, flags);
    end
    tick();
    // Trap beats halt and branch; counter parks at 1 while memory is busy.
    current_pc = 32'h30; trap_req = 1'b1; halt_req = 1'b1; branch_taken_ex = 1'b1;
    tick();
    idle(); imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (flags !== 5'b1_1_1_10) begin n_fail++; $display("FAIL trap_hold_%0d flags got=%b exp=%b", i, flags, 5'b1_1_1_10); end
      tick();
    end
    imem_ready = 1'b1;
    #1;
    n_checks++;
    if (next_pc !== 32'h100 || flags !== 5'b0_1_1_10) begin
      n_fail++; $display("FAIL trap_hold_exit next_pc=%h flags=%b exp 100/01110", next_pc, flags);
    end
    tick();
    // Trap during WAIT_MEM drops the pending redirect.
    current_pc = 32'h50; jump_id = 1'b1; jump_target = 32'hA00; imem_ready = 1'b0;
    tick();
    jump_id = 1'b0; trap_req = 1'b1; imem_ready = 1'b1;
    #1;
    n_checks++;
    if (flags !== 5'b1_1_1_01) begin n_fail++; $display("FAIL trap_wm flags got=%b exp=%b", flags, 5'b1_1_1_01); end
    tick();
    trap_req = 1'b0;
    tick();
    tick();
    current_pc = 32'h100;
    #1;
    n_checks++;
    if (next_pc !== 32'h104 || flags !== 5'b0_0_0_00) begin
      n_fail++; $display("FAIL trap_wm_after next_pc=%h flags=%b exp 104/00000", next_pc, flags);
    end
    tick();
    idle();
  endtask

  task automatic test_halt();
    idle();
    current_pc = 32'hC0; halt_req = 1'b1;
    #1;
    n_checks++;
    if (flags !== 5'b1_1_0_00) begin n_fail++; $display("FAIL halt_entry flags got=%b exp=%b", flags, 5'b1_1_0_00); end
    tick();
    for (int i = 0; i < 10; i++) begin
      halt_req        = 1'b0;
      jump_id         = i[0];
      branch_taken_ex = i[1];
      trap_req        = (i == 5);
      imem_ready      = i[2];
      #1;
      n_checks++;
      if (flags !== 5'b1_1_0_11) begin n_fail++; $display("FAIL halt_%0d flags got=%b exp=%b", i, flags, 5'b1_1_0_11); end
      tick();
    end
    idle();
    rst = 1'b1;
    #1;
    n_checks++;
    if (next_pc !== 32'h0 || flags !== 5'b0_1_1_00) begin
      n_fail++; $display("FAIL halt_rst next_pc=%h flags=%b exp 0/01100", next_pc, flags);
    end
    tick();
    rst = 1'b0; current_pc = 32'h0;
    #1;
    n_checks++;
    if (next_pc !== 32'h4 || flags !== 5'b0_0_0_00) begin
      n_fail++; $display("FAIL halt_restart next_pc=%h flags=%b exp 4/00000", next_pc, flags);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    idle();
    current_pc = 32'h70; jump_id = 1'b1; jump_target = 32'hB00; imem_ready = 1'b0;
    tick();
    jump_id = 1'b0;
    #1;
    n_checks++;
    if (seq_state !== 2'd1) begin n_fail++; $display("FAIL rstmid_wm state got=%0d exp=1", seq_state); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (next_pc !== 32'h0 || flags !== 5'b0_1_1_00) begin
      n_fail++; $display("FAIL rstmid_wm_rst next_pc=%h flags=%b exp 0/01100", next_pc, flags);
    end
    tick();
    rst = 1'b0; imem_ready = 1'b1; current_pc = 32'h0;
    #1;
    n_checks++;
    if (next_pc !== 32'h4 || flags !== 5'b0_0_0_00) begin
      n_fail++; $display("FAIL rstmid_wm_after next_pc=%h flags=%b exp 4/00000", next_pc, flags);
    end
    tick();
    trap_req = 1'b1;
    tick();
    trap_req = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (flags !== 5'b0_1_1_00) begin n_fail++; $display("FAIL rstmid_tf flags got=%b exp=%b", flags, 5'b0_1_1_00); end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (next_pc !== 32'h4 || flags !== 5'b0_0_0_00) begin
      n_fail++; $display("FAIL rstmid_tf_after next_pc=%h flags=%b exp 4/00000", next_pc, flags);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_jump();
    test_wait_mem();
    test_load_use();
    test_trap();
    test_halt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
